// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares a single-port synchronous RAM between instruction fetch (IF) and load/store (D).
// Grants one access per cycle and routes each read return to the requester that issued it.
module mem_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MEM_LAT  = 1,
    parameter int ARB_MODE = 0
) (
    input  logic          clk,
    input  logic          pcrst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic               r_pref_d;
    logic [MEM_LAT-1:0] r_tag_vld;
    logic [MEM_LAT-1:0] r_tag_own;
    logic [DW-1:0]      r_if_rdata;
    logic [DW-1:0]      r_d_rdata;

    logic w_contend;
    logic w_if_win;
    logic w_d_win;
    logic w_rd_issue;
    logic w_ret_vld;
    logic w_ret_d;

    // Grant: combinational, gated by reset so nothing reaches the RAM while held in reset
    always_comb begin
        w_contend = if_req & d_req;
        w_if_win  = 1'b0;
        w_d_win   = 1'b0;
        if (pcrst) begin
            if (w_contend) begin
                w_d_win  = (ARB_MODE == 1) ? 1'b1 : r_pref_d;
                w_if_win = ~w_d_win;
            end else begin
                w_if_win = if_req;
                w_d_win  = d_req;
            end
        end
    end

    assign if_gnt = w_if_win;
    assign d_gnt  = w_d_win;

    always_comb begin
        mem_en    = w_if_win | w_d_win;
        mem_we    = w_d_win & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_d_win) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (w_if_win) begin
            mem_addr  = if_addr;
        end
    end

    assign w_rd_issue = w_if_win | (w_d_win & ~d_we);

    // Round-robin pointer: only a contended grant moves it, towards the loser
    always_ff @(posedge clk or negedge pcrst) begin
        if (!pcrst) begin
            r_pref_d <= 1'b1;
        end else if (w_contend) begin
            r_pref_d <= ~w_d_win;
        end
    end

    // Tag pipeline: stage 0 tracks the access granted this cycle, last stage lines up with mem_rdata
    always_ff @(posedge clk or negedge pcrst) begin
        if (!pcrst) begin
            r_tag_vld <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_vld[0] <= w_rd_issue;
            r_tag_own[0] <= w_d_win;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_own[i] <= r_tag_own[i-1];
            end
        end
    end

    assign w_ret_vld = r_tag_vld[MEM_LAT-1];
    assign w_ret_d   = r_tag_own[MEM_LAT-1];
    assign if_rvalid = w_ret_vld & ~w_ret_d;
    assign d_rvalid  = w_ret_vld & w_ret_d;

    // Return: owner sees mem_rdata in the return cycle, each side otherwise shows its last return
    always_ff @(posedge clk or negedge pcrst) begin
        if (!pcrst) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (if_rvalid) r_if_rdata <= mem_rdata;
            if (d_rvalid)  r_d_rdata  <= mem_rdata;
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : r_if_rdata;
    assign d_rdata  = d_rvalid  ? mem_rdata : r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: three configurations driven by requester agents and a RAM model,
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NI = 3;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        int            due;
        bit            own_d;
        logic [DW-1:0] data;
    } ret_t;

    logic          clk;
    logic          pcrst;
    logic          if_req    [NI];
    logic [AW-1:0] if_addr   [NI];
    logic          if_gnt    [NI];
    logic          if_rvalid [NI];
    logic [DW-1:0] if_rdata  [NI];
    logic          d_req     [NI];
    logic          d_we      [NI];
    logic [AW-1:0] d_addr    [NI];
    logic [DW-1:0] d_wdata   [NI];
    logic          d_gnt     [NI];
    logic          d_rvalid  [NI];
    logic [DW-1:0] d_rdata   [NI];
    logic          mem_en    [NI];
    logic          mem_we    [NI];
    logic [AW-1:0] mem_addr  [NI];
    logic [DW-1:0] mem_wdata [NI];
    logic [DW-1:0] mem_rdata [NI];

    txn_t          ifq    [NI][$];
    txn_t          dq     [NI][$];
    ret_t          retq   [NI][$];
    logic [DW-1:0] ram    [NI][256];
    logic [DW-1:0] shadow [NI][256];
    logic [DW-1:0] pipe   [NI][4];
    bit            pref_d [NI];
    logic [DW-1:0] last_if[NI];
    logic [DW-1:0] last_d [NI];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit rand_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .ARB_MODE(0)) u_dut0 (
        .clk(clk), .pcrst(pcrst),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .ARB_MODE(1)) u_dut1 (
        .clk(clk), .pcrst(pcrst),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .ARB_MODE(0)) u_dut2 (
        .clk(clk), .pcrst(pcrst),
        .if_req(if_req[2]), .if_addr(if_addr[2]), .if_gnt(if_gnt[2]),
        .if_rvalid(if_rvalid[2]), .if_rdata(if_rdata[2]),
        .d_req(d_req[2]), .d_we(d_we[2]), .d_addr(d_addr[2]), .d_wdata(d_wdata[2]),
        .d_gnt(d_gnt[2]), .d_rvalid(d_rvalid[2]), .d_rdata(d_rdata[2]),
        .mem_en(mem_en[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]),
        .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata[2])
    );

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 3;
    endfunction

    function automatic bit fixed_prio(int k);
        return (k == 1);
    endfunction

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[inst %0d] cycle %0d: observed %0h expected %0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic push_if(int k, logic [AW-1:0] a);
        txn_t t;
        t.we = 1'b0; t.addr = a; t.data = '0;
        ifq[k].push_back(t);
    endtask

    task automatic push_d(int k, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.data = d;
        dq[k].push_back(t);
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NI; k++) begin
            if (rand_mode) begin
                if (ifq[k].size() > 0 && $urandom_range(0, 15) == 0) void'(ifq[k].pop_front());
                if (dq[k].size() > 0 && $urandom_range(0, 15) == 0) void'(dq[k].pop_front());
                if (ifq[k].size() < 2 && $urandom_range(0, 2) != 0)
                    push_if(k, AW'($urandom_range(0, 15)));
                if (dq[k].size() < 2 && $urandom_range(0, 2) != 0)
                    push_d(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            end
            if (ifq[k].size() > 0) begin
                if_req[k]  = 1'b1;
                if_addr[k] = ifq[k][0].addr;
            end else begin
                if_req[k]  = 1'b0;
                if_addr[k] = AW'($urandom);
            end
            if (dq[k].size() > 0) begin
                d_req[k]   = 1'b1;
                d_we[k]    = dq[k][0].we;
                d_addr[k]  = dq[k][0].addr;
                d_wdata[k] = dq[k][0].data;
            end else begin
                d_req[k]   = 1'b0;
                d_we[k]    = 1'($urandom);
                d_addr[k]  = AW'($urandom);
                d_wdata[k] = DW'($urandom);
            end
        end
    endtask

    task automatic step();
        bit            win_if, win_d;
        logic          exp_en, exp_we, exp_iv, exp_dv;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_wd, exp_ir, exp_dr;
        ret_t          r;
        logic          en_s [NI];
        logic          we_s [NI];
        logic [AW-1:0] a_s  [NI];
        logic [DW-1:0] wd_s [NI];
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            win_if = 1'b0;
            win_d  = 1'b0;
            if (!pcrst) begin
                retq[k].delete();
                pref_d[k]  = 1'b1;
                last_if[k] = '0;
                last_d[k]  = '0;
            end else if (if_req[k] && d_req[k]) begin
                win_d     = fixed_prio(k) ? 1'b1 : pref_d[k];
                win_if    = !win_d;
                pref_d[k] = !win_d;
            end else begin
                win_if = if_req[k];
                win_d  = d_req[k];
            end
            exp_en = win_if | win_d;
            exp_we = win_d & d_we[k];
            exp_a  = win_d ? d_addr[k] : (win_if ? if_addr[k] : '0);
            exp_wd = win_d ? d_wdata[k] : '0;
            exp_iv = 1'b0;
            exp_dv = 1'b0;
            if (pcrst && retq[k].size() > 0 && retq[k][0].due == cyc) begin
                r = retq[k].pop_front();
                if (r.own_d) begin
                    exp_dv    = 1'b1;
                    last_d[k] = r.data;
                end else begin
                    exp_iv     = 1'b1;
                    last_if[k] = r.data;
                end
            end
            exp_ir = last_if[k];
            exp_dr = last_d[k];

            chk("if_gnt",    k, 32'(if_gnt[k]),    32'(win_if));
            chk("d_gnt",     k, 32'(d_gnt[k]),     32'(win_d));
            chk("mem_en",    k, 32'(mem_en[k]),    32'(exp_en));
            chk("mem_we",    k, 32'(mem_we[k]),    32'(exp_we));
            chk("mem_addr",  k, 32'(mem_addr[k]),  32'(exp_a));
            chk("mem_wdata", k, 32'(mem_wdata[k]), 32'(exp_wd));
            chk("if_rvalid", k, 32'(if_rvalid[k]), 32'(exp_iv));
            chk("d_rvalid",  k, 32'(d_rvalid[k]),  32'(exp_dv));
            chk("if_rdata",  k, 32'(if_rdata[k]),  32'(exp_ir));
            chk("d_rdata",   k, 32'(d_rdata[k]),   32'(exp_dr));

            if (win_d && d_we[k]) shadow[k][d_addr[k]] = d_wdata[k];
            if (win_if) begin
                r.due = cyc + lat_of(k); r.own_d = 1'b0; r.data = shadow[k][if_addr[k]];
                retq[k].push_back(r);
                void'(ifq[k].pop_front());
            end
            if (win_d) begin
                if (!d_we[k]) begin
                    r.due = cyc + lat_of(k); r.own_d = 1'b1; r.data = shadow[k][d_addr[k]];
                    retq[k].push_back(r);
                end
                void'(dq[k].pop_front());
            end
            en_s[k] = mem_en[k];
            we_s[k] = mem_we[k];
            a_s[k]  = mem_addr[k];
            wd_s[k] = mem_wdata[k];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            for (int j = 3; j > 0; j--) pipe[k][j] = pipe[k][j-1];
            pipe[k][0] = (en_s[k] && !we_s[k]) ? ram[k][a_s[k]] : DW'($urandom);
            if (en_s[k] && we_s[k]) ram[k][a_s[k]] = wd_s[k];
            mem_rdata[k] = pipe[k][lat_of(k)-1];
        end
        cyc++;
        drive_inputs();
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 256; a++) begin
                v = DW'($urandom);
                ram[k][a]    = v;
                shadow[k][a] = v;
            end
            for (int j = 0; j < 4; j++) pipe[k][j] = '0;
            mem_rdata[k] = '0;
            pref_d[k]    = 1'b1;
            last_if[k]   = '0;
            last_d[k]    = '0;
        end

        // Reset held with both requesters asking, then D wins first after release
        pcrst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            push_if(k, 8'h05);
            push_d(k, 1'b0, 8'h06, 16'h0000);
        end
        drive_inputs();
        steps(5);
        pcrst = 1'b1;
        steps(6);

        // IF-only back-to-back reads
        for (int k = 0; k < NI; k++) begin
            push_if(k, 8'h10); push_if(k, 8'h11); push_if(k, 8'h12);
        end
        drive_inputs();
        steps(7);

        // Contention: both sides keep two requests queued
        for (int k = 0; k < NI; k++) begin
            push_if(k, 8'h40); push_if(k, 8'h41);
            push_d(k, 1'b0, 8'h50, 16'h0000); push_d(k, 1'b0, 8'h51, 16'h0000);
        end
        drive_inputs();
        steps(8);

        // D write followed by read of the same word
        for (int k = 0; k < NI; k++) begin
            push_d(k, 1'b1, 8'h20, 16'hBEEF);
            push_d(k, 1'b0, 8'h20, 16'h0000);
        end
        drive_inputs();
        steps(6);

        // Reset one cycle after an IF read grant discards the return
        for (int k = 0; k < NI; k++) push_if(k, 8'h30);
        drive_inputs();
        step();
        pcrst = 1'b0;
        step();
        pcrst = 1'b1;
        for (int k = 0; k < NI; k++) push_if(k, 8'h31);
        drive_inputs();
        steps(6);

        // Randomized traffic with occasional abandoned requests and a mid-run reset
        rand_mode = 1'b1;
        steps(1500);
        pcrst = 1'b0;
        step();
        pcrst = 1'b1;
        steps(1500);
        rand_mode = 1'b0;
        for (int i = 0; i < 40; i++) step();
        steps(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
